// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types: data words, register addresses, forwarding selects,
// ALU operation codes and the divider state encoding.
package rv32_pipeline_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } forward_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_DIV   = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_REM   = 4'd13,
    ALU_REMU  = 4'd14
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/rv32_divider.sv
// Iterative restoring divider: 32 RUN cycles plus one DONE cycle; /0 and overflow resolve in 0 cycles.
// busy is combinational on entry; hold keeps the result parked in DONE until downstream accepts.
module rv32_divider
  import rv32_pipeline_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  alu_op_t op,
  input  word_t   a,
  input  word_t   b,
  input  logic    flush,
  input  logic    hold,
  output logic    busy,
  output logic    done,
  output word_t   result
);

  div_state_t  state;
  logic [4:0]  count;
  word_t       quo, rem, divisor;
  logic        neg_q, neg_r, is_rem_q;

  logic        sgn, is_rem, div_zero, ovf, special;
  word_t       a_mag, b_mag, special_res, q_fix, r_fix, rem_next;
  logic [32:0] rem_sh;
  logic        rem_ge;

  always_comb begin
    sgn         = (op == ALU_DIV) || (op == ALU_REM);
    is_rem      = (op == ALU_REM) || (op == ALU_REMU);
    div_zero    = (b == '0);
    ovf         = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special     = div_zero || ovf;
    a_mag       = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag       = (sgn && b[31]) ? (~b + 32'd1) : b;
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? a : 32'hFFFF_FFFF;
    else if (ovf)
      special_res = is_rem ? 32'h0 : 32'h8000_0000;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so the difference fits in 32 bits.
  always_comb begin
    rem_sh   = {rem, quo[31]};
    rem_ge   = (rem_sh >= {1'b0, divisor});
    rem_next = rem_ge ? (rem_sh[31:0] - divisor) : rem_sh[31:0];
  end

  always_comb begin
    q_fix  = neg_q ? (~quo + 32'd1) : quo;
    r_fix  = neg_r ? (~rem + 32'd1) : rem;
    done   = (state == DIV_DONE);
    busy   = !rst && ((state == DIV_RUN) || ((state == DIV_IDLE) && start && !special));
    result = done ? (is_rem_q ? r_fix : q_fix) : special_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem_q <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !special) begin
            quo      <= a_mag;
            divisor  <= b_mag;
            rem      <= '0;
            neg_q    <= sgn && (a[31] ^ b[31]);
            neg_r    <= sgn && a[31];
            is_rem_q <= is_rem;
            count    <= '0;
            state    <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          rem   <= rem_next;
          quo   <= {quo[30:0], rem_ge};
          count <= count + 5'd1;
          if (count == 5'd31)
            state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!hold)
            state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rv32_ex_stage.sv
// RV32 execute stage: operand forwarding, single-cycle ALU (1 cycle to EX/MEM), 34-cycle divide.
// mem_stall holds EX/MEM; ex_busy holds ID/EX while the divider iterates, emitting bubbles.
module rv32_ex_stage
  import rv32_pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  word_t        id_rs1_data,
  input  word_t        id_rs2_data,
  input  forward_sel_t forward_rs1,
  input  forward_sel_t forward_rs2,
  input  word_t        mem_fwd_data,
  input  word_t        wb_fwd_data,
  input  word_t        id_imm,
  input  logic         id_use_imm,
  input  alu_op_t      id_alu_op,
  input  reg_addr_t    id_rd,
  input  logic         id_regwrite,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         mem_stall,
  input  logic         flush,
  output logic         ex_busy,
  output logic         exm_valid,
  output logic         exm_regwrite,
  output logic         exm_mem_read,
  output logic         exm_mem_write,
  output word_t        exm_result,
  output word_t        exm_store_data,
  output reg_addr_t    exm_rd
);

  word_t op_a, rs2_fwd, op_b, alu_result, div_result, ex_result;
  logic  is_div, div_busy, div_done, div_ready, load_ok;

  always_comb begin
    case (forward_rs1)
      FWD_MEM: op_a = mem_fwd_data;
      FWD_WB:  op_a = wb_fwd_data;
      default: op_a = id_rs1_data;
    endcase
    case (forward_rs2)
      FWD_MEM: rs2_fwd = mem_fwd_data;
      FWD_WB:  rs2_fwd = wb_fwd_data;
      default: rs2_fwd = id_rs2_data;
    endcase
    op_b = id_use_imm ? id_imm : rs2_fwd;
  end

  always_comb begin
    alu_result = '0;
    case (id_alu_op)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_SLL:   alu_result = op_a << op_b[4:0];
      ALU_SRL:   alu_result = op_a >> op_b[4:0];
      ALU_SRA:   alu_result = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:   alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {31'b0, op_a < op_b};
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

  assign is_div = is_div_op(id_alu_op);

  rv32_divider u_divider (
    .clk    (clk),
    .rst    (rst),
    .start  (id_valid && is_div),
    .op     (id_alu_op),
    .a      (op_a),
    .b      (op_b),
    .flush  (flush),
    .hold   (mem_stall),
    .busy   (div_busy),
    .done   (div_done),
    .result (div_result)
  );

  // A div retires either from DONE or as a zero-latency special case (never busy).
  assign div_ready = div_done || !div_busy;
  assign ex_busy   = div_busy;
  assign ex_result = is_div ? div_result : alu_result;
  assign load_ok   = id_valid && !flush && (!is_div || div_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid      <= 1'b0;
      exm_regwrite   <= 1'b0;
      exm_mem_read   <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_result     <= '0;
      exm_store_data <= '0;
      exm_rd         <= '0;
    end else if (!mem_stall) begin
      if (load_ok) begin
        exm_valid      <= 1'b1;
        exm_regwrite   <= id_regwrite;
        exm_mem_read   <= id_mem_read;
        exm_mem_write  <= id_mem_write;
        exm_result     <= ex_result;
        exm_store_data <= rs2_fwd;
        exm_rd         <= id_rd;
      end else begin
        exm_valid      <= 1'b0;
        exm_regwrite   <= 1'b0;
        exm_mem_read   <= 1'b0;
        exm_mem_write  <= 1'b0;
        exm_result     <= '0;
        exm_store_data <= '0;
        exm_rd         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_ex_stage.sv
// Directed bench for rv32_ex_stage: forwarding, ALU ops, divider timing, special cases,
// flush, stall in DONE and reset mid-division.
module tb_rv32_ex_stage;
  import rv32_pipeline_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid;
  word_t        id_rs1_data, id_rs2_data, mem_fwd_data, wb_fwd_data, id_imm;
  forward_sel_t forward_rs1, forward_rs2;
  logic         id_use_imm;
  alu_op_t      id_alu_op;
  reg_addr_t    id_rd;
  logic         id_regwrite, id_mem_read, id_mem_write;
  logic         mem_stall, flush;
  logic         ex_busy, exm_valid, exm_regwrite, exm_mem_read, exm_mem_write;
  word_t        exm_result, exm_store_data;
  reg_addr_t    exm_rd;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rv32_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_stall(mem_stall), .flush(flush), .ex_busy(ex_busy),
    .exm_valid(exm_valid), .exm_regwrite(exm_regwrite), .exm_mem_read(exm_mem_read),
    .exm_mem_write(exm_mem_write), .exm_result(exm_result),
    .exm_store_data(exm_store_data), .exm_rd(exm_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input alu_op_t op, input word_t a, input word_t b, input logic use_imm,
                        input word_t imm, input reg_addr_t rd);
    id_valid     = 1'b1;
    id_alu_op    = op;
    id_rs1_data  = a;
    id_rs2_data  = b;
    forward_rs1  = FWD_NONE;
    forward_rs2  = FWD_NONE;
    id_use_imm   = use_imm;
    id_imm       = imm;
    id_rd        = rd;
    id_regwrite  = 1'b1;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
  endtask

  task automatic set_idle();
    id_valid     = 1'b0;
    id_regwrite  = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    forward_rs1  = FWD_NONE;
    forward_rs2  = FWD_NONE;
    id_use_imm   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(ALU_ADD, 32'd11, 32'd22, 1'b0, 32'd0, 5'd9);
    tick();
    tick();
    checks++; if (exm_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", exm_valid); else passed++;
    checks++; if (exm_result !== 32'h0) $display("FAIL reset_result got %h want 0", exm_result); else passed++;
    checks++; if (exm_rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", exm_rd); else passed++;
    checks++; if (exm_regwrite !== 1'b0) $display("FAIL reset_regwrite got %0b want 0", exm_regwrite); else passed++;
    checks++; if (ex_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", ex_busy); else passed++;
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_forward_add();
    set_op(ALU_ADD, 32'd100, 32'd200, 1'b0, 32'd0, 5'd3);
    forward_rs1  = FWD_MEM;
    forward_rs2  = FWD_WB;
    mem_fwd_data = 32'd5;
    wb_fwd_data  = 32'd7;
    tick();
    checks++; if (exm_result !== 32'd12) $display("FAIL fwd_add_result got %h want %h", exm_result, 32'd12); else passed++;
    checks++; if (exm_valid !== 1'b1) $display("FAIL fwd_add_valid got %0b want 1", exm_valid); else passed++;
    checks++; if (exm_rd !== 5'd3) $display("FAIL fwd_add_rd got %0d want 3", exm_rd); else passed++;
    checks++; if (exm_store_data !== 32'd7) $display("FAIL fwd_add_store got %h want 7", exm_store_data); else passed++;
    // Store: address = rs1 + imm, store data = rs2 even though B is the immediate.
    set_op(ALU_ADD, 32'h100, 32'hAB, 1'b1, 32'd8, 5'd0);
    id_regwrite  = 1'b0;
    id_mem_write = 1'b1;
    tick();
    checks++; if (exm_result !== 32'h108) $display("FAIL store_addr got %h want 108", exm_result); else passed++;
    checks++; if (exm_store_data !== 32'hAB) $display("FAIL store_data got %h want ab", exm_store_data); else passed++;
    checks++; if (exm_mem_write !== 1'b1) $display("FAIL store_memwrite got %0b want 1", exm_mem_write); else passed++;
  endtask

  task automatic test_alu_back_to_back();
    alu_op_t op;
    word_t a, b, exp;
    logic ui;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin op = ALU_SRA;   a = 32'h8000_0000; b = 32'd4;         ui = 1'b1; exp = 32'hF800_0000; end
        1: begin op = ALU_SLTU;  a = 32'd1;         b = 32'hFFFF_FFFF; ui = 1'b0; exp = 32'd1;         end
        2: begin op = ALU_SUB;   a = 32'd5;         b = 32'd7;         ui = 1'b0; exp = 32'hFFFF_FFFE; end
        3: begin op = ALU_SLT;   a = 32'hFFFF_FFFF; b = 32'd1;         ui = 1'b0; exp = 32'd1;         end
        4: begin op = ALU_SLL;   a = 32'd1;         b = 32'h24;        ui = 1'b0; exp = 32'h10;        end
        5: begin op = ALU_SRL;   a = 32'h8000_0000; b = 32'd31;        ui = 1'b0; exp = 32'd1;         end
        default: begin op = ALU_PASSB; a = 32'd9;   b = 32'hDEAD_0000; ui = 1'b1; exp = 32'hDEAD_0000; end
      endcase
      set_op(op, a, ui ? 32'h1234_5678 : b, ui, b, 5'(i + 1));
      tick();
      checks++;
      if (exm_result !== exp || exm_valid !== 1'b1)
        $display("FAIL alu_%0d got %h/%0b want %h/1", i, exm_result, exm_valid, exp);
      else passed++;
    end
    set_idle();
    tick();
  endtask

  task automatic test_divide();
    alu_op_t op;
    word_t a, b, exp;
    int n;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op = ALU_DIV;  a = 32'hFFFF_FFF9; b = 32'd2;         exp = 32'hFFFF_FFFD; end
        1: begin op = ALU_REM;  a = 32'hFFFF_FFF9; b = 32'd2;         exp = 32'hFFFF_FFFF; end
        2: begin op = ALU_DIVU; a = 32'd100;       b = 32'd7;         exp = 32'd14;        end
        3: begin op = ALU_REMU; a = 32'd100;       b = 32'd7;         exp = 32'd2;         end
        default: begin op = ALU_REM; a = 32'd7;    b = 32'hFFFF_FFFE; exp = 32'd1;         end
      endcase
      set_op(op, 32'hCAFE_0000, b, 1'b0, 32'd0, 5'd10);
      forward_rs1  = FWD_MEM;
      mem_fwd_data = a;
      #1;
      n = 0;
      while (ex_busy && n < 100) begin
        n++;
        tick();
        mem_fwd_data = 32'h5555_5555;
      end
      checks++; if (n !== 33) $display("FAIL div_%0d_busy_cycles got %0d want 33", i, n); else passed++;
      checks++; if (exm_valid !== 1'b0) $display("FAIL div_%0d_bubble got %0b want 0", i, exm_valid); else passed++;
      tick();
      set_idle();
      checks++; if (exm_result !== exp) $display("FAIL div_%0d_result got %h want %h", i, exm_result, exp); else passed++;
      checks++; if (exm_valid !== 1'b1) $display("FAIL div_%0d_valid got %0b want 1", i, exm_valid); else passed++;
      tick();
    end
  endtask

  task automatic test_div_special();
    alu_op_t op;
    word_t a, b, exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin op = ALU_DIVU; a = 32'd1234;       b = 32'd0;         exp = 32'hFFFF_FFFF; end
        1: begin op = ALU_REMU; a = 32'd1234;       b = 32'd0;         exp = 32'd1234;      end
        2: begin op = ALU_DIV;  a = 32'h8000_0000;  b = 32'hFFFF_FFFF; exp = 32'h8000_0000; end
        3: begin op = ALU_REM;  a = 32'h8000_0000;  b = 32'hFFFF_FFFF; exp = 32'h0;         end
        4: begin op = ALU_DIV;  a = 32'hFFFF_FFFB;  b = 32'd0;         exp = 32'hFFFF_FFFF; end
        default: begin op = ALU_REM; a = 32'hFFFF_FFFB; b = 32'd0;     exp = 32'hFFFF_FFFB; end
      endcase
      set_op(op, a, b, 1'b0, 32'd0, 5'd12);
      #1;
      checks++; if (ex_busy !== 1'b0) $display("FAIL special_%0d_busy got %0b want 0", i, ex_busy); else passed++;
      tick();
      checks++;
      if (exm_result !== exp || exm_valid !== 1'b1)
        $display("FAIL special_%0d got %h/%0b want %h/1", i, exm_result, exm_valid, exp);
      else passed++;
    end
    set_idle();
    tick();
  endtask

  task automatic test_flush();
    set_op(ALU_DIV, 32'd100, 32'd3, 1'b0, 32'd0, 5'd7);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (ex_busy !== 1'b1) $display("FAIL flush_pre_busy got %0b want 1", ex_busy); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(ALU_ADD, 32'd2, 32'd3, 1'b0, 32'd0, 5'd4);
    #1;
    checks++; if (ex_busy !== 1'b0) $display("FAIL flush_busy got %0b want 0", ex_busy); else passed++;
    checks++; if (exm_valid !== 1'b0) $display("FAIL flush_bubble got %0b want 0", exm_valid); else passed++;
    tick();
    checks++; if (exm_result !== 32'd5 || exm_valid !== 1'b1) $display("FAIL flush_next_add got %h/%0b want 5/1", exm_result, exm_valid); else passed++;
    // flush together with mem_stall: divider aborts, EX/MEM keeps the ADD.
    set_op(ALU_ADD, 32'd9, 32'd1, 1'b0, 32'd0, 5'd6);
    tick();
    mem_stall = 1'b1;
    set_op(ALU_DIV, 32'd50, 32'd5, 1'b0, 32'd0, 5'd8);
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_stall = 1'b0;
    set_idle();
    #1;
    checks++; if (exm_result !== 32'd10 || exm_rd !== 5'd6) $display("FAIL flush_stall_hold got %h/%0d want a/6", exm_result, exm_rd); else passed++;
    checks++; if (ex_busy !== 1'b0) $display("FAIL flush_stall_busy got %0b want 0", ex_busy); else passed++;
    tick();
  endtask

  task automatic test_stall_done();
    int n;
    set_op(ALU_DIV, 32'd20, 32'hFFFF_FFFD, 1'b0, 32'd0, 5'd11);
    #1;
    n = 0;
    while (ex_busy && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n !== 33) $display("FAIL stall_busy_cycles got %0d want 33", n); else passed++;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (exm_valid !== 1'b0 || ex_busy !== 1'b0)
        $display("FAIL stall_hold_%0d got valid %0b busy %0b want 0/0", i, exm_valid, ex_busy);
      else passed++;
    end
    mem_stall = 1'b0;
    tick();
    set_idle();
    checks++; if (exm_result !== 32'hFFFF_FFFA || exm_valid !== 1'b1) $display("FAIL stall_result got %h/%0b want fffffffa/1", exm_result, exm_valid); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_div();
    set_op(ALU_DIVU, 32'd1000, 32'd9, 1'b0, 32'd0, 5'd13);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++; if (ex_busy !== 1'b0) $display("FAIL rst_mid_busy got %0b want 0", ex_busy); else passed++;
    checks++; if (exm_valid !== 1'b0 || exm_result !== 32'h0 || exm_rd !== 5'd0) $display("FAIL rst_mid_exm got %0b/%h/%0d want 0/0/0", exm_valid, exm_result, exm_rd); else passed++;
    tick();
    checks++; if (ex_busy !== 1'b0 || exm_valid !== 1'b0) $display("FAIL rst_mid_idle got busy %0b valid %0b want 0/0", ex_busy, exm_valid); else passed++;
    set_op(ALU_ADD, 32'd2, 32'd3, 1'b0, 32'd0, 5'd1);
    tick();
    checks++; if (exm_result !== 32'd5 || exm_valid !== 1'b1) $display("FAIL rst_mid_add got %h/%0b want 5/1", exm_result, exm_valid); else passed++;
    set_idle();
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    mem_stall    = 1'b0;
    flush        = 1'b0;
    mem_fwd_data = '0;
    wb_fwd_data  = '0;
    id_rs1_data  = '0;
    id_rs2_data  = '0;
    id_imm       = '0;
    id_rd        = '0;
    id_alu_op    = ALU_ADD;
    set_idle();
    test_reset();
    test_forward_add();
    test_alu_back_to_back();
    test_divide();
    test_div_special();
    test_flush();
    test_stall_done();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
